hazard_fwd_unit: RTL

//  Parametrised hazard/forwarding unit for the 5-stage MIPS pipeline (F/D/E/M/W).
//  - Keeps its own shadow pipeline of producer records (A3, Tnew) and consumer records (read addr, per stage).
//  - Produces forward selects for every read port at D, E and M, plus the D-stage stall.
//  - Models the multiply/divide unit busy window with a countdown, stalling HI/LO users.

---
 rtl/hazard_fwd_unit_pkg.sv | 22 ++
 rtl/hfu_port_match.sv | 56 +++++
 rtl/hazard_fwd_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared forwarding-select codes, Tnew/Tuse timing codes and MDU latency defaults
// for the hazard/forwarding unit.
package hazard_fwd_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Tnew: cycles after entering E until the result exists; Tuse: cycles until a read is consumed.
  typedef enum int {
    T_PC  = 0,
    T_ALU = 1,
    T_DM  = 2
  } t_code_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/hfu_port_match.sv
// Per-read-port hazard detect and forward select; purely combinational, zero latency.
// Sets stall when the nearest producer cannot deliver in time; it never applies backpressure itself.
module hfu_port_match
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) (
  input  logic [REG_AW-1:0] addr_d,
  input  logic [TW-1:0]     tuse_d,
  input  logic [REG_AW-1:0] addr_e,
  input  logic [REG_AW-1:0] addr_m,
  input  logic [REG_AW-1:0] a3_e,
  input  logic [TW-1:0]     tnew_e,
  input  logic [REG_AW-1:0] a3_m,
  input  logic [TW-1:0]     tnew_m,
  input  logic [REG_AW-1:0] a3_w,
  output logic              stall,
  output logic [1:0]        fwd_d,
  output logic [1:0]        fwd_e,
  output logic [1:0]        fwd_m
);

  logic d_hit_e, d_hit_m, d_hit_w;
  logic e_hit_m, e_hit_w;
  logic m_hit_w;
  logic e_rdy, m_rdy;

  // $0 is hard-wired, so a zero address never matches any producer.
  assign d_hit_e = (addr_d != '0) && (a3_e == addr_d);
  assign d_hit_m = (addr_d != '0) && (a3_m == addr_d);
  assign d_hit_w = (addr_d != '0) && (a3_w == addr_d);
  assign e_hit_m = (addr_e != '0) && (a3_m == addr_e);
  assign e_hit_w = (addr_e != '0) && (a3_w == addr_e);
  assign m_hit_w = (addr_m != '0) && (a3_w == addr_m);

  assign e_rdy = (tnew_e == TW'(T_PC));
  assign m_rdy = (tnew_m == TW'(T_PC));

  assign stall = (d_hit_e && (tnew_e > tuse_d)) ||
                 (d_hit_m && !d_hit_e && (tnew_m > tuse_d));

  // Nearest producer wins even when not ready; the stall covers that case.
  always_comb begin
    fwd_d = FWD_RF;
    fwd_e = FWD_RF;
    fwd_m = FWD_RF;
    if (d_hit_e)      fwd_d = e_rdy ? FWD_E : FWD_RF;
    else if (d_hit_m) fwd_d = m_rdy ? FWD_M : FWD_RF;
    else if (d_hit_w) fwd_d = FWD_W;
    if (e_hit_m)      fwd_e = m_rdy ? FWD_M : FWD_RF;
    else if (e_hit_w) fwd_e = FWD_W;
    if (m_hit_w)      fwd_m = FWD_W;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit for the 5-stage pipeline: shadow producer/consumer records plus MDU busy countdown.
// Outputs are combinational from D inputs and registered records; stall freezes F/D and bubbles E.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int NUM_RP      = 2,
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RP*REG_AW-1:0] rd_addr_D,
  input  logic [NUM_RP*TW-1:0]     rd_tuse_D,
  input  logic [REG_AW-1:0]        a3_D,
  input  logic [TW-1:0]            tnew_D,
  input  logic                     md_start_D,
  input  logic                     md_div_D,
  input  logic                     md_use_D,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_RP*2-1:0]      fwd_D,
  output logic [NUM_RP*2-1:0]      fwd_E,
  output logic [NUM_RP*2-1:0]      fwd_M,
  output logic                     md_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [REG_AW-1:0]        a3_e, a3_m, a3_w;
  logic [TW-1:0]            tnew_e, tnew_m;
  logic [NUM_RP*REG_AW-1:0] addr_e, addr_m;
  logic                     md_start_e, md_div_e;
  logic [CW-1:0]            md_cnt;
  logic [NUM_RP-1:0]        port_stall;
  logic                     md_stall;

  for (genvar i = 0; i < NUM_RP; i++) begin : g_port
    hfu_port_match #(
      .REG_AW (REG_AW),
      .TW     (TW)
    ) u_port_match (
      .addr_d (rd_addr_D[i*REG_AW +: REG_AW]),
      .tuse_d (rd_tuse_D[i*TW +: TW]),
      .addr_e (addr_e[i*REG_AW +: REG_AW]),
      .addr_m (addr_m[i*REG_AW +: REG_AW]),
      .a3_e   (a3_e),
      .tnew_e (tnew_e),
      .a3_m   (a3_m),
      .tnew_m (tnew_m),
      .a3_w   (a3_w),
      .stall  (port_stall[i]),
      .fwd_d  (fwd_D[i*2 +: 2]),
      .fwd_e  (fwd_E[i*2 +: 2]),
      .fwd_m  (fwd_M[i*2 +: 2])
    );
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = md_use_D && (md_start_e || md_busy);
  assign stall    = (|port_stall) || md_stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a3_e       <= '0;
      tnew_e     <= '0;
      addr_e     <= '0;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
      a3_m       <= '0;
      tnew_m     <= '0;
      addr_m     <= '0;
      a3_w       <= '0;
    end else if (flush) begin
      a3_e       <= '0;
      tnew_e     <= '0;
      addr_e     <= '0;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
      a3_m       <= '0;
      tnew_m     <= '0;
      addr_m     <= '0;
      a3_w       <= '0;
    end else begin
      if (stall) begin
        a3_e       <= '0;
        tnew_e     <= '0;
        addr_e     <= '0;
        md_start_e <= 1'b0;
        md_div_e   <= 1'b0;
      end else begin
        a3_e       <= a3_D;
        tnew_e     <= tnew_D;
        addr_e     <= rd_addr_D;
        md_start_e <= md_start_D;
        md_div_e   <= md_div_D;
      end
      a3_m   <= a3_e;
      tnew_m <= (tnew_e == TW'(T_PC)) ? tnew_e : tnew_e - TW'(1);
      addr_m <= addr_e;
      a3_w   <= a3_m;
    end
  end

  // An issued MDU op runs to completion; only reset stops the countdown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (md_start_e) begin
      md_cnt <= md_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_busy) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

endmodule
